// File: rtl/regbank_pkg.sv
// Shared widths and the write-back queue entry type
// for the 4x8-bit register bank write-back path.
package regbank_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] reg_idx;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-back queue: DEPTH entries of wb_entry_t.
// Ports: clock, reset_n (async, active-low);
//   push/push_entry enqueue, pop dequeue;
//   head = oldest entry, count, full, empty;
//   ord_entry/ord_valid = contents oldest-first,
//   used by the top for forwarding lookups.
module wb_fifo
    import regbank_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output wb_entry_t        ord_entry [DEPTH],
    output logic [DEPTH-1:0] ord_valid
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr] <= push_entry;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push)
                           - CNT_W'(do_pop);
        end
    end

    // Age-ordered view: index 0 is the oldest entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ord_entry[i] = mem_q[rd_ptr + PTR_W'(i)];
            ord_valid[i] = (CNT_W'(i) < count);
        end
    end

endmodule

// File: rtl/regbank_wb_ctrl.sv
// Write-back initiator for the register bank: arbitrates ALU and
// load requests into a queue, drains one bank write per cycle and
// forwards pending values to the decode read ports.
// Ports: clock, reset_n (async, active-low);
//   alu_*/mem_* valid/ready request channels (mem has priority);
//   wr_hold inhibits draining;
//   rd_addr1/2 -> fwd_hit1/2, fwd_data1/2 forwarding;
//   WriteReg/WriteData/RegWrite registered bank port;
//   busy = queue non-empty or write in flight.
module regbank_wb_ctrl
    import regbank_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wr_hold,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              fwd_hit1,
    output logic [DATA_W-1:0] fwd_data1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data2,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    output logic              busy
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        push_entry;
    wb_entry_t        head;
    wb_entry_t        ord_entry [DEPTH];
    logic [DEPTH-1:0] ord_valid;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Readiness depends on registered state only; a pop in the
    // same cycle does not free a slot early.
    assign mem_ready = reset_n & ~full;
    assign alu_ready = reset_n & ~full & ~mem_valid;

    assign push = (mem_valid & mem_ready)
                | (alu_valid & alu_ready);
    assign pop  = ~empty & ~wr_hold;
    assign busy = ~empty | RegWrite;

    always_comb begin
        push_entry = '0;
        if (mem_valid) begin
            push_entry.reg_idx = mem_reg;
            push_entry.data    = mem_data;
        end else begin
            push_entry.reg_idx = alu_reg;
            push_entry.data    = alu_data;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .ord_entry  (ord_entry),
        .ord_valid  (ord_valid)
    );

    // Bank write stage: address/data hold when idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            RegWrite <= pop;
            if (pop) begin
                WriteReg  <= head.reg_idx;
                WriteData <= head.data;
            end
        end
    end

    // Lowest priority first (output stage), then queue oldest to
    // youngest, so the last match left standing is the newest.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        if (RegWrite && WriteReg == rd_addr1) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = WriteData;
        end
        if (RegWrite && WriteReg == rd_addr2) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = WriteData;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (ord_valid[i]
                && ord_entry[i].reg_idx == rd_addr1) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = ord_entry[i].data;
            end
            if (ord_valid[i]
                && ord_entry[i].reg_idx == rd_addr2) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = ord_entry[i].data;
            end
        end
    end

endmodule

// File: tb/tb_regbank_wb_ctrl.sv
// Self-checking bench for regbank_wb_ctrl: directed vector table
// plus hand-written reset and streaming sequences.
module tb_regbank_wb_ctrl;

    logic       clock;
    logic       reset_n;
    logic       alu_valid;
    logic       alu_ready;
    logic [1:0] alu_reg;
    logic [7:0] alu_data;
    logic       mem_valid;
    logic       mem_ready;
    logic [1:0] mem_reg;
    logic [7:0] mem_data;
    logic       wr_hold;
    logic [1:0] rd_addr1;
    logic [1:0] rd_addr2;
    logic       fwd_hit1;
    logic [7:0] fwd_data1;
    logic       fwd_hit2;
    logic [7:0] fwd_data2;
    logic [1:0] WriteReg;
    logic [7:0] WriteData;
    logic       RegWrite;
    logic       busy;

    int checks;
    int failures;

    regbank_wb_ctrl #(.DEPTH(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_reg   (mem_reg),
        .mem_data  (mem_data),
        .wr_hold   (wr_hold),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .fwd_hit1  (fwd_hit1),
        .fwd_data1 (fwd_data1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data2 (fwd_data2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int av, ar, ad, mv, mr, md, h, r1, r2;
        int ear, emr, erw, ewr, ewd, eb;
        int eh1, ed1, eh2, ed2;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name,
                       input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h",
                     name, act, exp);
        end
    endtask

    task automatic add(
        input int av, ar, ad, mv, mr, md, h, r1, r2,
        input int ear, emr, erw, ewr, ewd, eb,
        input int eh1, ed1, eh2, ed2);
        vec_t v;
        v = '{av, ar, ad, mv, mr, md, h, r1, r2,
              ear, emr, erw, ewr, ewd, eb,
              eh1, ed1, eh2, ed2};
        vq.push_back(v);
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        alu_reg   = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_reg   = '0;
        mem_data  = '0;
        wr_hold   = 1'b0;
        rd_addr1  = '0;
        rd_addr2  = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        idle();

        // av ar ad mv mr md h r1 r2 | ear emr rw wr wd busy h1 d1 h2 d2
        // single write
        add(1,2,'h5A,0,0,0,0,2,0, 1,1,0,0,0,0,     0,0,0,0);
        add(0,0,0,0,0,0,0,2,0,     1,1,0,0,0,1,     1,'h5A,0,0);
        add(0,0,0,0,0,0,0,2,2,     1,1,1,2,'h5A,1,  1,'h5A,1,'h5A);
        add(0,0,0,0,0,0,0,2,0,     1,1,0,2,'h5A,0,  0,0,0,0);
        // simultaneous mem/alu
        add(1,3,'h33,1,1,'h11,0,1,3, 0,1,0,2,'h5A,0, 0,0,0,0);
        add(1,3,'h33,0,0,0,0,1,3,  1,1,0,2,'h5A,1,  1,'h11,0,0);
        add(0,0,0,0,0,0,0,1,3,     1,1,1,1,'h11,1,  1,'h11,1,'h33);
        add(0,0,0,0,0,0,0,1,3,     1,1,1,3,'h33,1,  0,0,1,'h33);
        add(0,0,0,0,0,0,0,0,0,     1,1,0,3,'h33,0,  0,0,0,0);
        // hold until full, then drain
        add(0,0,0,1,0,'hA0,1,0,1,  0,1,0,3,'h33,0,  0,0,0,0);
        add(1,1,'hA1,0,0,0,1,0,1,  1,1,0,3,'h33,1,  1,'hA0,0,0);
        add(1,2,'hEE,0,0,0,1,0,1,  0,0,0,3,'h33,1,  1,'hA0,1,'hA1);
        add(0,0,0,0,0,0,0,0,1,     0,0,0,3,'h33,1,  1,'hA0,1,'hA1);
        add(0,0,0,0,0,0,0,0,1,     1,1,1,0,'hA0,1,  1,'hA0,1,'hA1);
        add(0,0,0,0,0,0,0,0,1,     1,1,1,1,'hA1,1,  0,0,1,'hA1);
        add(0,0,0,0,0,0,0,0,1,     1,1,0,1,'hA1,0,  0,0,0,0);
        // forwarding newest duplicate, hold while RegWrite high
        add(1,1,'h11,0,0,0,1,1,3,  1,1,0,1,'hA1,0,  0,0,0,0);
        add(1,1,'h22,0,0,0,1,1,3,  1,1,0,1,'hA1,1,  1,'h11,0,0);
        add(0,0,0,0,0,0,1,1,3,     0,0,0,1,'hA1,1,  1,'h22,0,0);
        add(0,0,0,0,0,0,0,1,3,     0,0,0,1,'hA1,1,  1,'h22,0,0);
        add(0,0,0,0,0,0,1,1,3,     1,1,1,1,'h11,1,  1,'h22,0,0);
        add(0,0,0,0,0,0,1,1,3,     1,1,0,1,'h11,1,  1,'h22,0,0);
        add(0,0,0,0,0,0,0,1,3,     1,1,0,1,'h11,1,  1,'h22,0,0);
        add(0,0,0,0,0,0,0,1,3,     1,1,1,1,'h22,1,  1,'h22,0,0);
        add(0,0,0,0,0,0,0,1,3,     1,1,0,1,'h22,0,  0,0,0,0);

        #1;
        chk("rst_alu_ready", int'(alu_ready), 0);
        chk("rst_mem_ready", int'(mem_ready), 0);
        chk("rst_regwrite", int'(RegWrite), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            alu_valid = 1'(vq[i].av);
            alu_reg   = 2'(vq[i].ar);
            alu_data  = 8'(vq[i].ad);
            mem_valid = 1'(vq[i].mv);
            mem_reg   = 2'(vq[i].mr);
            mem_data  = 8'(vq[i].md);
            wr_hold   = 1'(vq[i].h);
            rd_addr1  = 2'(vq[i].r1);
            rd_addr2  = 2'(vq[i].r2);
            #1;
            chk($sformatf("v%0d_alu_ready", i),
                int'(alu_ready), vq[i].ear);
            chk($sformatf("v%0d_mem_ready", i),
                int'(mem_ready), vq[i].emr);
            chk($sformatf("v%0d_regwrite", i),
                int'(RegWrite), vq[i].erw);
            chk($sformatf("v%0d_writereg", i),
                int'(WriteReg), vq[i].ewr);
            chk($sformatf("v%0d_writedata", i),
                int'(WriteData), vq[i].ewd);
            chk($sformatf("v%0d_busy", i),
                int'(busy), vq[i].eb);
            chk($sformatf("v%0d_fwd_hit1", i),
                int'(fwd_hit1), vq[i].eh1);
            chk($sformatf("v%0d_fwd_data1", i),
                int'(fwd_data1), vq[i].ed1);
            chk($sformatf("v%0d_fwd_hit2", i),
                int'(fwd_hit2), vq[i].eh2);
            chk($sformatf("v%0d_fwd_data2", i),
                int'(fwd_data2), vq[i].ed2);
            @(negedge clock);
        end

        // reset with a write in flight and an entry queued
        idle();
        wr_hold   = 1'b1;
        alu_valid = 1'b1;
        alu_reg   = 2'd2;
        alu_data  = 8'h42;
        @(negedge clock);
        alu_reg   = 2'd3;
        alu_data  = 8'h43;
        @(negedge clock);
        idle();
        rd_addr1 = 2'd3;
        @(negedge clock);
        #1;
        chk("pre_rst_regwrite", int'(RegWrite), 1);
        chk("pre_rst_fwd_hit1", int'(fwd_hit1), 1);
        chk("pre_rst_busy", int'(busy), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_regwrite", int'(RegWrite), 0);
        chk("async_rst_writereg", int'(WriteReg), 0);
        chk("async_rst_writedata", int'(WriteData), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_mem_ready", int'(mem_ready), 0);
        chk("async_rst_fwd_hit1", int'(fwd_hit1), 0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            #1;
            chk($sformatf("post_rst%0d_regwrite", c),
                int'(RegWrite), 0);
            chk($sformatf("post_rst%0d_busy", c),
                int'(busy), 0);
        end

        // streaming: one ALU request per cycle
        @(negedge clock);
        for (int c = 0; c < 20; c++) begin
            if (c < 16) begin
                alu_valid = 1'b1;
                alu_reg   = 2'((c + 1) % 4);
                alu_data  = 8'(c + 1);
            end else begin
                alu_valid = 1'b0;
            end
            #1;
            if (c < 16) begin
                chk($sformatf("s%0d_alu_ready", c),
                    int'(alu_ready), 1);
            end
            if (c >= 2 && c <= 17) begin
                chk($sformatf("s%0d_regwrite", c),
                    int'(RegWrite), 1);
                chk($sformatf("s%0d_writereg", c),
                    int'(WriteReg), (c - 1) % 4);
                chk($sformatf("s%0d_writedata", c),
                    int'(WriteData), c - 1);
            end else begin
                chk($sformatf("s%0d_regwrite", c),
                    int'(RegWrite), 0);
            end
            @(negedge clock);
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
